// File: rtl/ext_pipe.sv
// Pipelined operand extender: widens an IN_W-bit field (or a 1-bit flag) to OUT_W bits
// behind a valid/ready interface with a 2-entry skid buffer and a transfer counter.
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_bit,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int PAD_W = OUT_W - IN_W;

    generate
        if (OUT_W <= IN_W || IN_W < 1) begin : g_bad_width
            $error("ext_pipe: OUT_W must be greater than IN_W and IN_W must be >= 1");
        end
    endgenerate

    // Handshake contract: a transfer happens on a rising edge where valid and ready
    // are both high; valid, once raised, holds its payload stable until ready is seen.
    // in_ready comes straight from the skid register, so it never depends on out_ready.

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             fire;
    logic [OUT_W-1:0] ext_val;

    assign in_ready   = ~skid_valid_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign xfer_count = cnt_q;

    assign accept = in_valid & ~skid_valid_q;
    assign fire   = out_valid_q & out_ready;

    always_comb begin
        ext_val = '0;
        unique case (mode)
            2'd0: ext_val = {{PAD_W{1'b0}}, in_data};
            2'd1: ext_val = {{PAD_W{in_data[IN_W-1]}}, in_data};
            2'd2: ext_val = {in_data, {PAD_W{1'b0}}};
            default: ext_val = {{(OUT_W-1){1'b0}}, in_bit};
        endcase
    end

    // Registers only load ext_val under accept, so idle-cycle garbage never lands.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        cnt_d        = cnt_q;

        if (fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (fire && skid_valid_q) begin
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (fire && accept) begin
            out_data_d = ext_val;
        end else if (fire) begin
            out_valid_d = 1'b0;
        end else if (!out_valid_q && accept) begin
            out_data_d  = ext_val;
            out_valid_d = 1'b1;
        end else if (out_valid_q && accept) begin
            skid_data_d  = ext_val;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: directed mode/stream/backpressure/reset/wrap cases plus random
// stress, checked by an in-order scoreboard fed from a behavioural extension model.
module tb_ext_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int CNT_W = 4;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_bit = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic [CNT_W-1:0] xfer_count;

    ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_bit     (in_bit),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_count (xfer_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // reference model: extension expressed arithmetically
    function automatic logic [31:0] model_f(input logic [1:0] m, input logic [15:0] d, input logic b);
        case (m)
            2'd0:    return 32'(d);
            2'd1:    return 32'($signed(d));
            2'd2:    return 32'(d) << 16;
            default: return 32'(b);
        endcase
    endfunction

    // scoreboard
    logic [OUT_W-1:0] exp_q[$];
    int exp_cnt = 0;
    bit mon_en = 1'b1;

    always @(negedge clk) begin
        bit can_acc;
        bit do_fire;
        if (reset) begin
            exp_q.delete();
            exp_cnt = 0;
        end else if (mon_en) begin
            can_acc = (exp_q.size() < 2);
            do_fire = out_ready && (exp_q.size() != 0);
            check("mon_in_ready", 32'(in_ready), 32'(can_acc));
            check("mon_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("mon_out_data", out_data, exp_q[0]);
            check("mon_xfer_count", 32'(xfer_count), 32'(exp_cnt));
            if (do_fire) begin
                void'(exp_q.pop_front());
                exp_cnt = (exp_cnt + 1) % 16;
            end
            if (in_valid && can_acc) exp_q.push_back(model_f(mode, in_data, in_bit));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drive(input logic [1:0] m, input logic [15:0] d, input logic b);
        mode = m;
        in_data = d;
        in_bit = b;
        in_valid = 1'b1;
    endtask

    task automatic send_check(input string name, input logic [1:0] m, input logic [15:0] d,
                              input logic b, input logic [31:0] exp);
        out_ready = 1'b1;
        drive(m, d, b);
        tick();
        in_valid = 1'b0;
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check(name, out_data, exp);
        tick();
    endtask

    task automatic drain();
        int budget = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        do_reset();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_data", out_data, 32'd0);
        check("reset_xfer_count", 32'(xfer_count), 32'd0);

        // modes
        send_check("m0_8001", 2'd0, 16'h8001, 1'b0, 32'h0000_8001);
        send_check("m1_8001", 2'd1, 16'h8001, 1'b0, 32'hFFFF_8001);
        send_check("m1_7fff", 2'd1, 16'h7FFF, 1'b0, 32'h0000_7FFF);
        send_check("m2_1234", 2'd2, 16'h1234, 1'b0, 32'h1234_0000);
        send_check("m3_bit1", 2'd3, 16'hFFFF, 1'b1, 32'h0000_0001);

        // streaming
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(2'(i % 4), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
            tick();
            check("stream_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_count", 32'(xfer_count), 32'd8);
        check("stream_idle", 32'(out_valid), 32'd0);

        // backpressure
        do_reset();
        drive(2'd0, 16'h0005, 1'b0);
        tick();
        drive(2'd0, 16'h0006, 1'b0);
        tick();
        in_valid = 1'b0;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_hold_data", out_data, 32'h5);
        tick();
        check("bp_hold_data2", out_data, 32'h5);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_second", out_data, 32'h6);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_count", 32'(xfer_count), 32'd2);

        // async reset mid-stall with both entries full
        out_ready = 1'b0;
        drive(2'd1, 16'h8000, 1'b0);
        tick();
        drive(2'd2, 16'h00AB, 1'b0);
        tick();
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_data", out_data, 32'd0);
        check("arst_xfer_count", 32'(xfer_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // random stress
        for (int c = 0; c < 10000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            mode = 2'($urandom_range(0, 3));
            in_data = 16'($urandom_range(0, 65535));
            in_bit = 1'($urandom_range(0, 1));
            tick();
        end
        drain();

        // counter wrap
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            drive(2'd0, 16'(i), 1'b0);
            tick();
            in_valid = 1'b0;
            tick();
            if (i == 15) check("wrap_15", 32'(xfer_count), 32'd15);
            if (i == 16) check("wrap_0", 32'(xfer_count), 32'd0);
            if (i == 17) check("wrap_1", 32'(xfer_count), 32'd1);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined operand extender for the MIPS datapath.
- Widens an IN_W-bit field, or a single 1-bit flag such as an SLT result, to OUT_W bits.
- Four modes: zero-extend, sign-extend, upper placement (LUI-style) and flag-extend.
- Registered output behind a valid/ready interface with a 2-entry skid buffer, so it can sit between pipeline stages without a combinational ready path.

Parameters:
- IN_W, 16, width of the in_data field (>= 1)
- OUT_W, 32, width of out_data (must be > IN_W; elaboration error otherwise)
- CNT_W, 16, width of the transfer counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream has an operand
- in_ready  output  1  block can accept this cycle
- in_data  input  IN_W  field to extend
- in_bit  input  1  flag operand (mode 3 only)
- mode  input  2  0 zero-ext, 1 sign-ext, 2 upper placement, 3 flag-ext
- out_valid  output  1  out_data holds a result
- out_ready  input  1  downstream accepts
- out_data  output  OUT_W  extended result
- xfer_count  output  CNT_W  number of completed output handshakes

Behaviour:
- Extension function f(mode, in_data, in_bit) is evaluated on the accept cycle and registered. Mode/data are not stored raw.
  - mode 0: {(OUT_W-IN_W) zeros, in_data}
  - mode 1: {(OUT_W-IN_W) copies of in_data[IN_W-1], in_data}
  - mode 2: {in_data, (OUT_W-IN_W) zeros}, i.e. in_data shifted left by OUT_W-IN_W
  - mode 3: {(OUT_W-1) zeros, in_bit}; in_data is ignored
- Accept = in_valid & in_ready. Fire = out_valid & out_ready.
- Storage: main register (out_valid/out_data) and skid register (skid_valid/skid_data).
- in_ready = ~skid_valid, driven directly from a register with no combinational path from out_ready.
- Per-cycle update, in priority order:
  - Fire & skid_valid: main <= skid; skid_valid <= 0. No accept is possible this cycle because in_ready = 0.
  - Fire & ~skid_valid & accept: main <= f(new); out_valid stays 1.
  - Fire & ~skid_valid & ~accept: out_valid <= 0.
  - ~out_valid & accept: main <= f(new); out_valid <= 1.
  - out_valid & ~out_ready & accept: skid <= f(new); skid_valid <= 1.
  - Otherwise: hold.
- Latency: accept in cycle N gives out_valid in cycle N+1 (when main is empty or drains in N).
- Throughput: 1 result per cycle with out_ready held high.
- Stall: out_data and out_valid remain stable while out_valid & ~out_ready. After one extra accept, in_ready drops until the next fire.
- Ordering: strictly FIFO; the skid entry is never bypassed.
- xfer_count increments by 1 on every fire and wraps from 2^CNT_W-1 to 0.
- Reset (async, any time, including mid-stall):
  - out_valid = 0, skid_valid = 0, in_ready = 1
  - out_data = 0, skid_data = 0, xfer_count = 0
  - Pending data is discarded.
- Deassertion of reset takes effect at the next clk edge. An accept is possible in the first cycle after deassertion.
- X on in_data/mode while in_valid = 0 must not propagate into the registers.

Test Plan:
- Reset: assert reset mid-stall with both entries full -> out_valid=0, in_ready=1, out_data=0, xfer_count=0 immediately, without waiting for a clk edge.
- Modes, IN_W=16, OUT_W=32, out_ready=1:
  - mode0 0x8001 -> 0x00008001
  - mode1 0x8001 -> 0xFFFF8001
  - mode1 0x7FFF -> 0x00007FFF
  - mode2 0x1234 -> 0x12340000
  - mode3 in_bit=1, in_data=0xFFFF -> 0x00000001
  - each result appears exactly one cycle after accept
- Streaming: 8 back-to-back accepts with out_ready=1 -> 8 results on consecutive cycles, in order; in_ready stays 1; xfer_count=8.
- Backpressure:
  - out_ready=0 after 0x00000005 is held; accept 0x0006 (mode0) -> in_ready=0 next cycle; out_data stays 0x00000005.
  - Then raise out_ready -> 0x00000005 fires, then 0x00000006 fires the next cycle, and in_ready returns to 1.
- Random stress: random in_valid and out_ready for 10k cycles -> scoreboard matches f() in order; no loss or duplication; out_data stable during every stall.
- Counter wrap: CNT_W=4, 17 fires -> xfer_count goes 15 -> 0 -> 1.
